// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR protocol: owns MAR, MDR and a
// word-addressed RAM, with optional wait states and a backdoor preload port.
module lc3_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              memWE,
  input  logic [15:0]       bus,
  output logic [15:0]       mdrOut,
  output logic [15:0]       marOut,
  output logic              memReady,
  output logic              errOverlap,
  input  logic              loadWE,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [15:0]       loadData
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state, nextState;
  logic [3:0]        counter;
  logic [15:0]       mar, mdr, capData;
  logic [ADDR_W-1:0] capAddr, marIdx;
  logic [15:0]       ram [DEPTH];

  logic              isIdle, frontReq, rdReq, wrReq, lastWait, loadOk;
  logic              ramWe;
  logic [ADDR_W-1:0] ramIdx;
  logic [15:0]       ramData;

  // Upper MAR bits are ignored, so addresses alias modulo DEPTH.
  assign marIdx   = mar[ADDR_W-1:0];
  assign isIdle   = (state == IDLE);
  assign frontReq = ldMAR | ldMDR | memWE;
  assign wrReq    = isIdle & memWE;
  assign rdReq    = isIdle & ldMDR & selMDR & ~memWE;
  assign lastWait = ~isIdle & (counter == 4'd1);
  assign loadOk   = isIdle & loadWE & ~frontReq;
  assign mdrOut   = mdr;
  assign marOut   = mar;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (LATENCY > 0) begin
          if (wrReq)      nextState = WR_WAIT;
          else if (rdReq) nextState = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: if (lastWait) nextState = IDLE;
      default:          nextState = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    memReady = isIdle;
    ramWe    = 1'b0;
    ramIdx   = loadAddr;
    ramData  = loadData;
    if (loadOk) begin
      ramWe = 1'b1;
    end else if (wrReq && LATENCY == 0) begin
      ramWe   = resetN;
      ramIdx  = marIdx;
      ramData = mdr;
    end else if (state == WR_WAIT && lastWait) begin
      ramWe   = resetN;
      ramIdx  = capAddr;
      ramData = capData;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      counter    <= 4'd0;
      mar        <= 16'h0000;
      mdr        <= 16'h0000;
      capAddr    <= '0;
      capData    <= 16'h0000;
      errOverlap <= 1'b0;
    end else if (isIdle) begin
      if (ldMAR) mar <= bus;
      if (ldMDR && !selMDR)             mdr <= bus;
      else if (rdReq && LATENCY == 0)   mdr <= ram[marIdx];
      // Address and data are captured from pre-edge MAR/MDR.
      if (wrReq || rdReq) begin
        capAddr <= marIdx;
        capData <= mdr;
        counter <= LAT4;
      end
      if ((memWE && ldMDR && selMDR) || (loadWE && frontReq)) errOverlap <= 1'b1;
    end else begin
      counter <= counter - 4'd1;
      if (state == RD_WAIT && lastWait) mdr <= ram[capAddr];
      if (frontReq || loadWE) errOverlap <= 1'b1;
    end
  end

  // NOTE: the RAM array has no reset on purpose; preloaded contents must
  // survive resetN, and resetting a memory would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (ramWe) ram[ramIdx] <= ramData;
  end

endmodule
